// File: rtl/match_seq.sv
// Multi-cycle pattern search: finds the lowest bit offset where src1[PAT_W-1:0]
// appears inside src2, testing one offset per cycle while holding busy high.
module match_seq #(
    parameter int DATA_W = 32,
    parameter int PAT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              flush,
    input  logic              stall,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [31:0]       match_result
);

    localparam int LAST  = DATA_W - PAT_W;
    localparam int CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PAT_W-1:0]    r_pat;
    logic [PAT_W-1:0]    w_pat_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_found;
    logic                w_found_nxt;
    logic [31:0]         r_result;
    logic [31:0]         w_result_nxt;
    logic                w_hit;
    logic                w_last;

    // Only the low PAT_W bits of src1 form the pattern.
    if (DATA_W > PAT_W) begin : g_src1_upper
        logic w_unused_src1;
        assign w_unused_src1 = ^src1[DATA_W-1:PAT_W];
    end

    assign w_hit  = (r_shift[PAT_W-1:0] == r_pat);
    assign w_last = (r_cnt == CNT_W'(LAST));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_pat    <= '0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pat    <= w_pat_nxt;
            r_shift  <= w_shift_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_found  <= w_found_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pat_nxt    = r_pat;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;
        w_found_nxt  = r_found;
        w_result_nxt = r_result;

        case (r_state)
            IDLE: begin
                if (start && !flush) begin
                    w_pat_nxt   = src1[PAT_W-1:0];
                    w_shift_nxt = src2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                // flush wins over stall and over a match in the same cycle
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (!stall) begin
                    if (w_hit) begin
                        w_found_nxt  = 1'b1;
                        w_result_nxt = 32'(r_cnt);
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = IDLE;
                    end else if (w_last) begin
                        w_found_nxt  = 1'b0;
                        w_result_nxt = '1;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy         = (r_state == SCAN);
    assign done         = r_done;
    assign found        = r_found;
    assign match_result = r_result;

endmodule

// File: tb/tb_match_seq.sv
// Randomized and directed bench for match_seq against a transaction-level
// model: expected offset from a window search, latency from a cycle budget.
module tb_match_seq;

    localparam int DW   = 32;
    localparam int PW   = 8;
    localparam int LAST = DW - PW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic [DW-1:0] src1 = '0;
    logic [DW-1:0] src2 = '0;
    logic          busy;
    logic          done;
    logic          found;
    logic [31:0]   match_result;

    match_seq #(.DATA_W(DW), .PAT_W(PW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .flush        (flush),
        .stall        (stall),
        .src1         (src1),
        .src2         (src2),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .match_result (match_result)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_found = 0;
    logic [31:0] m_res = '0;
    int          m_rem = 0;
    bit          m_pend_found = 0;
    logic [31:0] m_pend_res = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_offset(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i <= LAST; i++)
            if (((b >> i) & 32'hFF) == (a & 32'hFF)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_found = 0; m_res = '0; m_rem = 0;
    endtask

    task automatic model_edge();
        int off;
        m_done = 0;
        if (m_busy) begin
            if (flush) m_busy = 0;
            else if (!stall) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy  = 0;
                    m_done  = 1;
                    m_found = m_pend_found;
                    m_res   = m_pend_res;
                end
            end
        end else if (start && !flush) begin
            off = ref_offset(src1, src2);
            m_busy = 1;
            if (off >= 0) begin
                m_rem = off + 1; m_pend_found = 1; m_pend_res = 32'(off);
            end else begin
                m_rem = LAST + 1; m_pend_found = 0; m_pend_res = 32'hFFFF_FFFF;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},  32'(busy),  32'(m_busy));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".found"}, 32'(found), 32'(m_found));
        chk({tag, ".res"},   match_result, m_res);
    endtask

    task automatic step(input logic st, input logic fl, input logic sl,
                        input logic [31:0] a, input logic [31:0] b, input string tag);
        start = st; flush = fl; stall = sl; src1 = a; src2 = b;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // accept then run until DUT done (bounded), checking latency and result
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic exp_found, input logic [31:0] exp_res, input string tag);
        int n;
        step(1, 0, 0, a, b, {tag, ".acc"});
        n = 0;
        do begin
            step(0, 0, 0, $urandom, $urandom, tag);
            n++;
        end while (done !== 1'b1 && n < 40);
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".found_c"}, 32'(found), 32'(exp_found));
        chk({tag, ".res_c"}, match_result, exp_res);
    endtask

    initial begin
        int n;
        logic [7:0]  pat;
        logic [31:0] a, b;
        int off;

        #12;
        check_all("reset");
        @(negedge clk) resetn = 1'b1;
        step(0, 0, 0, '0, '0, "idle");

        run_op(32'h0000_00AB, 32'h0000_00AB, 1, 1'b1, 32'd0, "t_off0");
        run_op(32'h0000_005A, 32'h5A00_0000, 25, 1'b1, 32'd24, "t_off24");
        run_op(32'h0000_005A, 32'h0000_B400, 10, 1'b1, 32'd9, "t_off9");
        run_op(32'h0000_00FF, 32'h0000_0000, 25, 1'b0, 32'hFFFF_FFFF, "t_nomatch");

        // stall for 3 cycles mid-scan, with an ignored start during SCAN
        step(1, 0, 0, 32'h5A, 32'h5A00_0000, "t_stall.acc");
        n = 0;
        for (int i = 0; i < 5; i++) begin step(0, 0, 0, '0, '0, "t_stall"); n++; end
        step(1, 0, 0, 32'hAB, 32'hAB, "t_stall.st"); n++;
        for (int i = 0; i < 3; i++) begin step(0, 0, 1, '0, '0, "t_stall.hold"); n++; end
        while (done !== 1'b1 && n < 40) begin step(0, 0, 0, '0, '0, "t_stall"); n++; end
        chk("t_stall.lat", 32'(n), 32'd28);
        chk("t_stall.res_c", match_result, 32'd24);

        // flush mid-scan keeps prior result
        step(1, 0, 0, 32'hFF, 32'h0, "t_flush.acc");
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, "t_flush");
        step(0, 1, 0, '0, '0, "t_flush.fl");
        chk("t_flush.busy_c", 32'(busy), 32'd0);
        chk("t_flush.done_c", 32'(done), 32'd0);
        chk("t_flush.res_c", match_result, 32'd24);
        step(1, 0, 0, 32'h12, 32'h12, "t_flush.re");
        step(0, 0, 0, '0, '0, "t_flush.re_d");
        chk("t_flush.re_done_c", 32'(done), 32'd1);
        chk("t_flush.re_res_c", match_result, 32'd0);

        // start with flush in IDLE is not accepted
        step(1, 1, 0, 32'h12, 32'h12, "t_stfl");
        chk("t_stfl.busy_c", 32'(busy), 32'd0);

        // asynchronous reset between edges
        step(1, 0, 0, 32'h5A, 32'h5A00_0000, "t_arst.acc");
        for (int i = 0; i < 6; i++) step(0, 0, 0, '0, '0, "t_arst");
        #3 resetn = 1'b0;
        model_reset();
        #1;
        check_all("t_arst.async");
        @(negedge clk) resetn = 1'b1;
        run_op(32'h0000_005A, 32'h0000_B400, 10, 1'b1, 32'd9, "t_arst.after");

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            pat = 8'($urandom_range(0, 255));
            b = $urandom;
            if ($urandom % 2 == 0) begin
                off = $urandom_range(0, LAST);
                b[off +: 8] = pat;
            end else if ($urandom % 8 == 0) begin
                b = '0;
            end
            a = $urandom;
            a[7:0] = pat;
            step(($urandom % 4) == 0, ($urandom % 25) == 0, ($urandom % 6) == 0, a, b, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
